// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// uart_pkg: constants and types shared by the UART blocks.
//   DEFAULT_CLK_FREQ / DEFAULT_BAUD : default system clock (Hz) and line rate (bit/s)
//   uart_state_e                    : frame sequencer states (IDLE, START, DATA, STOP)
//   counter_width()                 : width of a 0..n-1 counter, never less than 1 bit
package uart_pkg;

  localparam int unsigned DEFAULT_CLK_FREQ = 50_000_000;
  localparam int unsigned DEFAULT_BAUD     = 115_200;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  function automatic int unsigned counter_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
`timescale 1ns/1ps
// uart_bit_timer: restartable bit-period counter.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset, clears the count
//   restart  : holds the count at zero; the next period starts when released
//   bit_done : high during the last cycle of each CLKS_PER_BIT-cycle period
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_done
);

  localparam int unsigned CW = counter_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign bit_done = (count == LAST);

endmodule

// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// uart_tx: 8N1 UART transmitter, one byte per accepted request.
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset, aborts any frame in progress
//   data_in : byte to send, sampled only in the accepting cycle
//   start   : level request, accepted at any rising edge while idle
//   txd     : serial line, idle high, registered
//   busy    : high from acceptance until the stop bit completes, registered
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int unsigned BAUD     = DEFAULT_BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       start,
  output logic       txd,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;

  uart_state_e state, state_next;
  logic [7:0]  shreg, shreg_next;
  logic [2:0]  bit_idx, bit_idx_next;
  logic        txd_next, busy_next;
  logic        bit_done;

  // Timer is held at zero while idle, so every frame's baud timing starts
  // exactly at the acceptance edge.
  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (state == IDLE),
    .bit_done(bit_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      txd     <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      bit_idx <= bit_idx_next;
      txd     <= txd_next;
      busy    <= busy_next;
    end
  end

  // txd/busy are computed for the state being entered so the registered
  // outputs change on the same edge as the state.
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_idx_next = bit_idx;
    txd_next     = txd;
    busy_next    = busy;
    unique case (state)
      IDLE: begin
        txd_next  = 1'b1;
        busy_next = 1'b0;
        if (start) begin
          state_next = START;
          shreg_next = data_in;
          txd_next   = 1'b0;
          busy_next  = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_next   = DATA;
          bit_idx_next = '0;
          txd_next     = shreg[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            txd_next   = 1'b1;
          end else begin
            // Shift so the next bit to send is always at position 0.
            bit_idx_next = bit_idx + 3'd1;
            shreg_next   = {1'b0, shreg[7:1]};
            txd_next     = shreg[1];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          state_next = IDLE;
          txd_next   = 1'b1;
          busy_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
// tb_uart_tx: self-checking bench for uart_tx at default clock and baud.
// Expected line levels come from the frame {stop, byte, start} indexed by
// elapsed cycles / bit period.
module tb_uart_tx;

  localparam int CPB   = 50_000_000 / 115_200;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data_in;
  logic       txd;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  uart_tx dut (
    .clk    (clk),
    .rst    (rst),
    .data_in(data_in),
    .start  (start),
    .txd    (txd),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("%s idle%0d txd", tag, i), txd, 1'b1);
      chk($sformatf("%s idle%0d busy", tag, i), busy, 1'b0);
    end
  endtask

  // Requests byte b and follows the frame cycle by cycle.
  // hold     : number of edges start stays high (ignored when noise=1)
  // noise    : scramble data_in and start every cycle while busy
  // keep     : leave start high at frame end (back-to-back request)
  // abort_at : frame cycle at which rst is pulsed, -1 for none
  // Returns positioned at the first idle cycle (or after the reset edge).
  task automatic run_frame(input string tag, input logic [7:0] b, input int hold,
                           input bit noise, input bit keep, input int abort_at);
    logic [9:0] frame;
    int pos;
    frame   = {1'b1, b, 1'b0};
    data_in = b;
    start   = 1'b1;
    tick();
    for (int c = 0; c <= FRAME; c++) begin
      if (c < FRAME) begin
        pos = c % CPB;
        if (pos == 0 || pos == CPB / 2 || pos == CPB - 1) begin
          chk($sformatf("%s c%0d txd", tag, c), txd, frame[c / CPB]);
          chk($sformatf("%s c%0d busy", tag, c), busy, 1'b1);
        end
      end else begin
        chk($sformatf("%s end txd", tag), txd, 1'b1);
        chk($sformatf("%s end busy", tag), busy, 1'b0);
      end
      if (c == abort_at) begin
        rst   = 1'b1;
        start = 1'b0;
        tick();
        chk($sformatf("%s abort txd", tag), txd, 1'b1);
        chk($sformatf("%s abort busy", tag), busy, 1'b0);
        rst = 1'b0;
        return;
      end
      if (c == FRAME) break;
      if (noise) begin
        data_in = 8'($urandom);
        start   = 1'($urandom_range(0, 1));
      end else if (c + 1 >= hold) begin
        start = 1'b0;
      end
      tick();
    end
    if (!keep) start = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    rst     = 1'b1;
    start   = 1'b1;
    data_in = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("reset%0d txd", i), txd, 1'b1);
      chk($sformatf("reset%0d busy", i), busy, 1'b0);
    end
    rst   = 1'b0;
    start = 1'b0;
    idle_check("post_reset", 2);

    run_frame("a5", 8'hA5, 1, 1'b0, 1'b0, -1);
    idle_check("a5", 3);

    run_frame("3c_hold", 8'h3C, CPB, 1'b0, 1'b0, -1);
    idle_check("3c_hold", 3);

    r = 8'($urandom);
    run_frame("noise", r, 1, 1'b1, 1'b0, -1);
    idle_check("noise", 3);

    r = 8'($urandom);
    run_frame("b2b0", r, FRAME + 2, 1'b0, 1'b1, -1);
    r = 8'($urandom);
    run_frame("b2b1", r, FRAME + 2, 1'b0, 1'b1, -1);
    r = 8'($urandom);
    run_frame("b2b2", r, 1, 1'b0, 1'b0, -1);
    idle_check("b2b", 2);

    run_frame("abort", 8'hC3, 1, 1'b0, 1'b0, 4 * CPB + CPB / 2);
    idle_check("abort", 2);

    run_frame("55", 8'h55, 1, 1'b0, 1'b0, -1);
    idle_check("55", 2);

    r = 8'($urandom);
    run_frame("rand", r, 1, 1'b0, 1'b0, -1);
    idle_check("rand", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
